udp_ingress_arb: RTL and testbench

Packet-level round-robin arbiter that merges up to `N_PORTS` framed byte streams into the single write port of the UDP block's input FIFO. Each requester is the read side of a first-word-fall-through packet FIFO (byte plus SOF/EOF flags). The arbiter grants one port per packet and never interleaves bytes of different packets. It also drops unframed bytes and truncates over-length packets, so the UDP parser always receives well-formed SOF…EOF frames.

---
 rtl/udp_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/udp_ingress_arb.sv | 206 ++++++++++++++++++++
 tb/tb_udp_ingress_arb.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP ingress path.
package udp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned DEFAULT_MAX_LEN = 1518;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after i_ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [IDX_W-1:0] w_cand;

    // Scan ptr+1 .. ptr+N (mod N); the first hit wins.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_cand = IDX_W'((32'(i_ptr) + k) % N);
            if (!o_valid && i_req[w_cand]) begin
                o_valid        = 1'b1;
                o_idx          = w_cand;
                o_gnt          = '0;
                o_gnt[w_cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udp_ingress_arb.sv
// Packet-level round-robin merge of N framed byte FIFOs into one writer.
// Drops unframed bytes, truncates over-length packets.
module udp_ingress_arb
    import udp_pkg::*;
#(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned MAX_LEN = DEFAULT_MAX_LEN,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_PORTS-1:0]        req_empty,
    input  logic [N_PORTS*BYTE_W-1:0] req_dout,
    input  logic [N_PORTS-1:0]        req_sof,
    input  logic [N_PORTS-1:0]        req_eof,
    output logic [N_PORTS-1:0]        req_rd_en,
    input  logic                      out_full,
    output logic                      out_wr_en,
    output logic [BYTE_W-1:0]         out_din,
    output logic                      out_wr_sof,
    output logic                      out_wr_eof,
    output logic [N_PORTS-1:0]        grant,
    output logic [CNT_W-1:0]          pkt_cnt,
    output logic [CNT_W-1:0]          drop_cnt,
    output logic                      err_pulse
);

    localparam int unsigned IDX_W  = $clog2(N_PORTS);
    localparam int unsigned LEN_W  = $clog2(MAX_LEN) + 1;
    localparam int unsigned DROP_W = IDX_W + 1;
    localparam int unsigned SUM_W  = CNT_W + 1;
    localparam logic [LEN_W-1:0] LAST_LEN = LEN_W'(MAX_LEN - 1);

    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [N_PORTS-1:0] r_grant;
    logic [IDX_W-1:0]   r_gidx;
    logic [LEN_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_pkt_cnt;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic               r_err;

    logic [BYTE_W-1:0]  w_bytes [N_PORTS];
    logic [N_PORTS-1:0] w_elig;
    logic [N_PORTS-1:0] w_junk;
    logic [N_PORTS-1:0] w_win;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_win_vld;
    logic               w_g_empty;
    logic               w_g_sof;
    logic               w_g_eof;
    logic               w_at_last;
    logic               w_xfer;
    logic               w_pkt_inc;
    logic               w_err;
    logic [DROP_W-1:0]  w_drop_n;
    logic [SUM_W-1:0]   w_drop_sum;
    logic [CNT_W-1:0]   w_drop_nxt;

    // Unpack the per-port head bytes so the owner can be selected by index.
    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            w_bytes[i] = req_dout[i*BYTE_W +: BYTE_W];
        end
    end

    assign w_elig    = ~req_empty & req_sof;
    assign w_junk    = ~req_empty & ~req_sof;
    assign w_g_empty = req_empty[r_gidx];
    assign w_g_sof   = req_sof[r_gidx];
    assign w_g_eof   = req_eof[r_gidx];
    assign w_at_last = (r_len == LAST_LEN);

    rr_arbiter #(
        .N     (N_PORTS),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req   (w_elig),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_win),
        .o_idx   (w_win_idx),
        .o_valid (w_win_vld)
    );

    // Per-state pop/write decode; every output is forced low while reset is high.
    always_comb begin
        req_rd_en  = '0;
        out_wr_en  = 1'b0;
        out_din    = '0;
        out_wr_sof = 1'b0;
        out_wr_eof = 1'b0;
        w_xfer     = 1'b0;
        w_pkt_inc  = 1'b0;
        w_err      = 1'b0;
        w_drop_n   = '0;
        case (r_state)
            IDLE: begin
                // Unframed heads are discarded in parallel while arbitrating.
                req_rd_en = w_junk;
                for (int i = 0; i < N_PORTS; i++) begin
                    w_drop_n = w_drop_n + DROP_W'(w_junk[i]);
                end
            end
            PASS: begin
                w_xfer = !w_g_empty && !out_full;
                if (w_xfer) begin
                    req_rd_en  = r_grant;
                    out_wr_en  = 1'b1;
                    out_din    = w_bytes[r_gidx];
                    out_wr_sof = (r_len == '0);
                    out_wr_eof = w_g_eof || w_at_last;
                    w_pkt_inc  = out_wr_eof;
                    w_err      = (w_g_sof && (r_len != '0)) || (w_at_last && !w_g_eof);
                end
            end
            DRAIN: begin
                // Tail of a truncated packet: discard regardless of out_full.
                if (!w_g_empty) begin
                    req_rd_en = r_grant;
                    w_drop_n  = DROP_W'(1);
                end
            end
            default: begin
            end
        endcase
        if (reset) begin
            req_rd_en  = '0;
            out_wr_en  = 1'b0;
            out_din    = '0;
            out_wr_sof = 1'b0;
            out_wr_eof = 1'b0;
        end
    end

    // Saturating add of this cycle's dropped-byte count.
    always_comb begin
        w_drop_sum = {1'b0, r_drop_cnt} + SUM_W'(w_drop_n);
        w_drop_nxt = w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
    end

    // Arbitration FSM, packet owner, length counter and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rr_ptr <= IDX_W'(N_PORTS - 1);
            r_grant  <= '0;
            r_gidx   <= '0;
            r_len    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_win_vld) begin
                        r_grant <= w_win;
                        r_gidx  <= w_win_idx;
                        r_len   <= '0;
                        r_state <= PASS;
                    end
                end
                PASS: begin
                    if (w_xfer) begin
                        r_len <= r_len + LEN_W'(1);
                        if (w_g_eof) begin
                            r_state  <= IDLE;
                            r_rr_ptr <= r_gidx;
                            r_grant  <= '0;
                        end else if (w_at_last) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!w_g_empty && w_g_eof) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= r_gidx;
                        r_grant  <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Statistics counters and the registered error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err      <= w_err;
            r_drop_cnt <= w_drop_nxt;
            if (w_pkt_inc && (r_pkt_cnt != '1)) begin
                r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
            end
        end
    end

    assign grant     = r_grant;
    assign pkt_cnt   = r_pkt_cnt;
    assign drop_cnt  = r_drop_cnt;
    assign err_pulse = r_err;

endmodule

// File: tb/tb_udp_ingress_arb.sv
// Self-checking bench: per-port source FIFOs plus a frame-level reference model.
module tb_udp_ingress_arb;

    localparam int NP = 4;
    localparam int ML = 8;
    localparam int CW = 16;

    logic            clk;
    logic            reset;
    logic [NP-1:0]   req_empty;
    logic [NP*8-1:0] req_dout;
    logic [NP-1:0]   req_sof;
    logic [NP-1:0]   req_eof;
    logic [NP-1:0]   req_rd_en;
    logic            out_full;
    logic            out_wr_en;
    logic [7:0]      out_din;
    logic            out_wr_sof;
    logic            out_wr_eof;
    logic [NP-1:0]   grant;
    logic [CW-1:0]   pkt_cnt;
    logic [CW-1:0]   drop_cnt;
    logic            err_pulse;

    udp_ingress_arb #(
        .N_PORTS (NP),
        .MAX_LEN (ML),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_empty  (req_empty),
        .req_dout   (req_dout),
        .req_sof    (req_sof),
        .req_eof    (req_eof),
        .req_rd_en  (req_rd_en),
        .out_full   (out_full),
        .out_wr_en  (out_wr_en),
        .out_din    (out_din),
        .out_wr_sof (out_wr_sof),
        .out_wr_eof (out_wr_eof),
        .grant      (grant),
        .pkt_cnt    (pkt_cnt),
        .drop_cnt   (drop_cnt),
        .err_pulse  (err_pulse)
    );

    always #5 clk = ~clk;

    // Entries are {sof, eof, byte}.
    logic [9:0] src_q [NP][$];
    logic [9:0] exp_q [NP][$];
    logic [NP-1:0] stall;
    logic [NP-1:0] rd_s;

    int n_cmp, n_mis, cyc;
    int exp_drop, exp_pkt, exp_err;
    int err_seen, wr_count, last_eof_cyc, first_grant_cyc;
    logic [NP-1:0] first_grant;
    int sof_order[$];
    int gap_q[$];
    int p_stall, p_full;
    logic full_toggle, chk_bp, timed_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_model();
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            exp_q[p].delete();
        end
        stall = '0;
        rd_s = '0;
        exp_drop = 0; exp_pkt = 0; exp_err = 0;
        err_seen = 0; wr_count = 0;
        last_eof_cyc = -1; first_grant_cyc = -1; first_grant = '0;
        sof_order.delete();
        gap_q.delete();
    endtask

    // Expected behaviour follows the framing rules directly: junk and tail bytes are
    // counted as drops, the first ML bytes of each packet come out with SOF/EOF fixed up.
    task automatic add_packet(input int p, input int len, input int stray, input int junk);
        logic [7:0] b;
        logic s, e;
        for (int j = 0; j < junk; j++) begin
            b = 8'($urandom);
            src_q[p].push_back({2'b00, b});
            exp_drop++;
        end
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom);
            s = (k == 0) || (k == stray);
            e = (k == len - 1);
            src_q[p].push_back({s, e, b});
            if (k < ML) begin
                exp_q[p].push_back({(k == 0), (e || (k == ML - 1)), b});
                if ((k > 0 && s) || (k == ML - 1 && !e)) exp_err++;
            end else begin
                exp_drop++;
            end
        end
        exp_pkt++;
    endtask

    task automatic drive_inputs();
        logic [9:0] e;
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() > 0 && !stall[p]) begin
                e = src_q[p][0];
                req_empty[p] = 1'b0;
                req_sof[p] = e[9];
                req_eof[p] = e[8];
                req_dout[p*8 +: 8] = e[7:0];
            end else begin
                req_empty[p] = 1'b1;
                req_sof[p] = 1'($urandom);
                req_eof[p] = 1'($urandom);
                req_dout[p*8 +: 8] = 8'($urandom);
            end
        end
    endtask

    task automatic randomize_ctl();
        for (int p = 0; p < NP; p++) stall[p] = (int'($urandom_range(99)) < p_stall);
        if (full_toggle) out_full = cyc[0];
        else out_full = (int'($urandom_range(99)) < p_full);
    endtask

    task automatic monitor();
        int gi;
        logic [9:0] e;
        cyc++;
        rd_s = req_rd_en;
        check("pop_when_empty", 32'(req_rd_en & req_empty), 0);
        if (grant != '0) check("pop_nongranted", 32'(req_rd_en & ~grant), 0);
        if (chk_bp && out_full) check("bp_pop_while_full", 32'(req_rd_en), 0);
        if (err_pulse) err_seen++;
        if (grant != '0 && first_grant_cyc < 0) begin
            first_grant_cyc = cyc;
            first_grant = grant;
        end
        if (out_wr_en) begin
            wr_count++;
            check("wr_while_full", 32'(out_full), 0);
            check("grant_onehot", 32'($countones(grant)), 1);
            check("rd_eq_grant", 32'(req_rd_en), 32'(grant));
            gi = 0;
            for (int i = 0; i < NP; i++) if (grant[i]) gi = i;
            check("wr_expected", 32'(exp_q[gi].size() > 0), 1);
            if (exp_q[gi].size() > 0) begin
                e = exp_q[gi].pop_front();
                check("wr_sof_eof_byte", 32'({out_wr_sof, out_wr_eof, out_din}), 32'(e));
            end
            if (out_wr_sof) begin
                sof_order.push_back(gi);
                if (last_eof_cyc >= 0) gap_q.push_back(cyc - last_eof_cyc);
            end
            if (out_wr_eof) last_eof_cyc = cyc;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (rd_s[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
        end
        randomize_ctl();
        drive_inputs();
    endtask

    function automatic logic all_empty();
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() != 0 || exp_q[p].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic run_until_empty(input int bound);
        int n;
        n = 0;
        timed_out = 1'b0;
        while (!all_empty() && n < bound) begin
            step();
            n++;
        end
        if (n >= bound) timed_out = 1'b1;
        check("drain_timeout", 32'(timed_out), 0);
        repeat (3) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        out_full = 1'b0;
        clear_model();
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_mode(input int ps, input int pf, input logic tog, input logic bp);
        p_stall = ps; p_full = pf; full_toggle = tog; chk_bp = bp;
    endtask

    initial begin
        int t0, n;
        n_cmp = 0; n_mis = 0; cyc = 0;
        clk = 1'b0; reset = 1'b0; out_full = 1'b0;
        set_mode(0, 0, 1'b0, 1'b0);
        clear_model();
        drive_inputs();
        #1 reset = 1'b1;
        #2;
        check("rst_grant", 32'(grant), 0);
        check("rst_wr_en", 32'(out_wr_en), 0);
        check("rst_rd_en", 32'(req_rd_en), 0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        check("rst_err", 32'(err_pulse), 0);

        // Single 5-byte packet on port 1.
        do_reset();
        add_packet(1, 5, -1, 0);
        drive_inputs();
        t0 = cyc;
        run_until_empty(200);
        check("sp_grant", 32'(first_grant), 32'(4'b0010));
        check("sp_latency", 32'(first_grant_cyc - t0), 2);
        check("sp_writes", 32'(wr_count), 5);
        check("sp_pkt_cnt", 32'(pkt_cnt), 1);

        // All ports loaded with two 3-byte packets: strict rotation, one idle gap.
        do_reset();
        for (int r = 0; r < 2; r++) for (int p = 0; p < NP; p++) add_packet(p, 3, -1, 0);
        drive_inputs();
        run_until_empty(400);
        check("rr_count", 32'(sof_order.size()), 8);
        for (int i = 0; i < sof_order.size(); i++) check("rr_order", 32'(sof_order[i]), i % NP);
        check("rr_gap_count", 32'(gap_q.size()), 7);
        for (int i = 0; i < gap_q.size(); i++) check("rr_gap", 32'(gap_q[i]), 2);
        check("rr_pkt_cnt", 32'(pkt_cnt), 8);

        // Backpressure toggling every other cycle.
        do_reset();
        set_mode(0, 0, 1'b1, 1'b1);
        add_packet(3, 7, -1, 0);
        drive_inputs();
        run_until_empty(400);
        check("bp_writes", 32'(wr_count), 7);
        check("bp_pkt_cnt", 32'(pkt_cnt), 1);
        set_mode(0, 0, 1'b0, 1'b0);

        // Truncation: 12 bytes into an 8-byte limit, then a normal packet.
        do_reset();
        add_packet(2, 12, -1, 0);
        add_packet(2, 4, -1, 0);
        drive_inputs();
        run_until_empty(400);
        check("tr_writes", 32'(wr_count), 12);
        check("tr_err", 32'(err_seen), 1);
        check("tr_drop_cnt", 32'(drop_cnt), 4);
        check("tr_pkt_cnt", 32'(pkt_cnt), 2);

        // Junk in IDLE on two ports in parallel, then a packet with a stray SOF.
        do_reset();
        add_packet(1, 0, -1, 2);
        add_packet(3, 0, -1, 1);
        exp_pkt = 0;
        add_packet(0, 5, 2, 0);
        drive_inputs();
        run_until_empty(400);
        check("junk_drop_cnt", 32'(drop_cnt), 3);
        check("stray_err", 32'(err_seen), 1);
        check("stray_pkt_cnt", 32'(pkt_cnt), 1);

        // Reset asserted mid-packet.
        do_reset();
        add_packet(1, 6, -1, 0);
        drive_inputs();
        n = 0;
        while (wr_count < 3 && n < 100) begin
            step();
            n++;
        end
        timed_out = (n >= 100);
        check("mr_reach_byte3", 32'(timed_out), 0);
        #2 reset = 1'b1;
        #1;
        check("mr_wr_en", 32'(out_wr_en), 0);
        check("mr_rd_en", 32'(req_rd_en), 0);
        check("mr_grant", 32'(grant), 0);
        check("mr_flags", 32'({out_wr_sof, out_wr_eof, out_din}), 0);
        check("mr_pkt_cnt", 32'(pkt_cnt), 0);
        clear_model();
        add_packet(1, 3, -1, 0);
        add_packet(0, 3, -1, 0);
        drive_inputs();
        @(posedge clk);
        #1 reset = 1'b0;
        run_until_empty(200);
        check("mr_pkts_after", 32'(sof_order.size()), 2);
        check("mr_first_port", 32'(sof_order[0]), 0);

        // Randomised traffic with stalls, backpressure, junk, truncation, stray SOFs.
        for (int round = 0; round < 2; round++) begin
            do_reset();
            set_mode(25, 30, 1'b0, 1'b0);
            for (int p = 0; p < NP; p++) begin
                for (int k = 0; k < 12; k++) begin
                    int len, stray;
                    len = int'($urandom_range(12, 1));
                    stray = (len > 1 && $urandom_range(5) == 0) ?
                            int'($urandom_range(len - 1, 1)) : -1;
                    add_packet(p, len, stray, int'($urandom_range(2)));
                end
            end
            drive_inputs();
            run_until_empty(20000);
            check("rnd_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkt));
            check("rnd_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
            check("rnd_err_count", 32'(err_seen), 32'(exp_err));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
